// File: rtl/wait_timer_pkg.sv
// rtl/wait_timer_pkg.sv - shared encodings and defaults for the wait timer
package wait_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_FREERUN = 1'b1;

    localparam int DEFAULT_RESET_LIMIT = 6;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - start/abort controlled terminal-count timer with wrap counter
module wait_timer
    import wait_timer_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int RESET_LIMIT = DEFAULT_RESET_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             cnt_en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] wraps
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] wraps_q;
    logic             wraps_clr;
    logic             wraps_inc;

    // Next-state decode: abort overrides everything; start only matters in IDLE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        wraps_clr = 1'b0;
        wraps_inc = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RUN;
                        limit_d   = limit;
                        mode_d    = mode;
                        count_d   = '0;
                        wraps_clr = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_en) begin
                        if (count_q == limit_q) begin
                            count_d   = '0;
                            done_d    = 1'b1;
                            wraps_inc = 1'b1;
                            if (mode_q == MODE_ONESHOT) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // FSM, counter and latched run configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= WIDTH'(RESET_LIMIT);
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Terminal-count tally, cleared on an accepted start and pinned at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wraps_q <= '0;
        end else if (wraps_clr) begin
            wraps_q <= '0;
        end else if (wraps_inc && (wraps_q != '1)) begin
            wraps_q <= wraps_q + 1'b1;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign wraps = wraps_q;

endmodule
